// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle add/sub/slt/and/or, iterative shift-add multiply.
// Define ALU_EXEC_EARLY_TERM_EN to end a multiply once the multiplier runs out.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [2:0]       ALU_Control,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_nxt;
  logic             mul_last;

  // Single-cycle result selection
  always_comb begin
    op_res = '0;
    case (ALU_Control)
      3'b010:  op_res = SrcA + SrcB;
      3'b100:  op_res = SrcA - SrcB;
      3'b110:  op_res = {{(WIDTH-1){1'b0}},
                         $signed(SrcA) < $signed(SrcB)};
      3'b000:  op_res = SrcA & SrcB;
      3'b001:  op_res = SrcA | SrcB;
      default: op_res = '0;
    endcase
  end

  // Next accumulator value and the last-iteration test
  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : '0);
`ifdef ALU_EXEC_EARLY_TERM_EN
    mul_last = ((mplier >> 1) == '0) ||
               (cnt == CW'(WIDTH - 1));
`else
    mul_last = (cnt == CW'(WIDTH - 1));
`endif
  end

  // Control FSM with registered result, flags and multiply datapath
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      ALU_Result <= '0;
      Zero       <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            if (ALU_Control == 3'b101) begin
              acc    <= '0;
              mcand  <= SrcA;
              mplier <= SrcB;
              cnt    <= '0;
              Busy   <= 1'b1;
              state  <= MUL;
            end else begin
              ALU_Result <= op_res;
              Zero       <= (op_res == '0);
              Done       <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            ALU_Result <= acc_nxt;
            Zero       <= (acc_nxt == '0);
            Done       <= 1'b1;
            Busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit.
// Expected results are queued at issue and checked on each Done.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         Start = 1'b0;
  logic [2:0]   ALU_Control = 3'b000;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic [W-1:0] ALU_Result;
  logic         Zero;
  logic         Busy;
  logic         Done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .CLK(CLK),
    .RST(RST),
    .Start(Start),
    .ALU_Control(ALU_Control),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .ALU_Result(ALU_Result),
    .Zero(Zero),
    .Busy(Busy),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest queued expectation
  always @(negedge CLK) begin
    if (Done) begin
      exp_t e;
      checks++;
      if (Busy) begin
        errors++;
        $display("FAIL done_busy: Busy %b with Done, expected 0", Busy);
      end
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_done: result %h, expected no Done",
                 ALU_Result);
      end else begin
        e = sb.pop_front();
        if (ALU_Result !== e.res || Zero !== e.zero) begin
          errors++;
          $display("FAIL result: got %h/%b expected %h/%b",
                   ALU_Result, Zero, e.res, e.zero);
        end
      end
    end
  end

  task automatic push(logic [W-1:0] r);
    exp_t e;
    e.res  = r;
    e.zero = (r == '0);
    sb.push_back(e);
  endtask

  // Present an op and let one edge take it; Start is left high
  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    Start       = 1'b1;
    ALU_Control = op;
    SrcA        = a;
    SrcB        = b;
    @(posedge CLK);
    #1;
  endtask

  // Count Busy cycles while poking Start; returns the count
  task automatic busy_wait(output int n);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      Start       = 1'b1;
      ALU_Control = 3'b010;
      SrcA        = W'(n);
      SrcB        = 32'h100;
      @(posedge CLK);
      #1;
      Start = 1'b0;
    end
  endtask

  task automatic mul_run(string name, logic [W-1:0] a,
                         logic [W-1:0] b, logic [W-1:0] r, int lat);
    int n;
    push(r);
    issue(3'b101, a, b);
    Start = 1'b0;
    busy_wait(n);
    chk({name, "_lat"}, W'(n), W'(lat));
    chk({name, "_done"}, W'(Done), W'(1));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    int t;
    // reset, with Start held high so reset must win
    Start       = 1'b1;
    ALU_Control = 3'b010;
    SrcA        = 32'd3;
    SrcB        = 32'd4;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_result", ALU_Result, '0);
    chk("rst_zero", W'(Zero), W'(1));
    chk("rst_busy", W'(Busy), W'(0));
    chk("rst_done", W'(Done), W'(0));
    Start = 1'b0;
    RST   = 1'b1;
    @(posedge CLK);
    #1;
    chk("idle_done", W'(Done), W'(0));

    // back-to-back single-cycle ops
    push(32'd7);
    issue(3'b010, 32'd3, 32'd4);
    chk("b2b_done0", W'(Done), W'(1));
    push(32'd0);
    issue(3'b100, 32'd5, 32'd5);
    chk("b2b_done1", W'(Done), W'(1));
    chk("b2b_zero1", W'(Zero), W'(1));
    push(32'd1);
    issue(3'b110, 32'hFFFF_FFFF, 32'd1);
    chk("b2b_done2", W'(Done), W'(1));
    Start = 1'b0;
    @(posedge CLK);
    #1;
    chk("b2b_idle", W'(Done), W'(0));

    // logic ops and unused codes
    push(32'h0000_0F00);
    issue(3'b000, 32'h0000_FF00, 32'h0F0F_0F0F);
    push(32'hF0F0_FFFF);
    issue(3'b001, 32'hF0F0_0000, 32'h0000_FFFF);
    push(32'd0);
    issue(3'b011, 32'd9, 32'd9);
    push(32'd0);
    issue(3'b111, 32'd9, 32'd9);
    push(32'd0);
    issue(3'b110, 32'd1, 32'hFFFF_FFFF);
    Start = 1'b0;
    @(posedge CLK);
    #1;

    // multiplies
    mul_run("mul_a", 32'h0001_0003, 32'd7, 32'h0007_0015, W);
    mul_run("mul_trunc", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, W);
`ifdef ALU_EXEC_EARLY_TERM_EN
    mul_run("mul_9x5", 32'd9, 32'd5, 32'd45, 3);
    mul_run("mul_9x0", 32'd9, 32'd0, 32'd0, 1);
`else
    mul_run("mul_9x5", 32'd9, 32'd5, 32'd45, W);
    mul_run("mul_9x0", 32'd9, 32'd0, 32'd0, W);
`endif
    chk("mul_zero", W'(Zero), W'(1));

    // reset mid-multiply: no Done and result cleared
    push(32'd11);
    issue(3'b010, 32'd5, 32'd6);
    Start = 1'b0;
    @(posedge CLK);
    #1;
    issue(3'b101, 32'h1234, 32'hFFFF_FFFF);
    Start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("abort_busy_pre", W'(Busy), W'(1));
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("abort_busy", W'(Busy), W'(0));
    chk("abort_result", ALU_Result, '0);
    chk("abort_zero", W'(Zero), W'(1));
    repeat (W + 2) @(posedge CLK);
    #1;
    chk("abort_nodone", W'(Done), W'(0));
    push(32'd100);
    issue(3'b010, 32'd40, 32'd60);
    Start = 1'b0;
    chk("post_done", W'(Done), W'(1));
    chk("post_result", ALU_Result, 32'd100);

    // drain
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      t++;
      @(posedge CLK);
    end
    #1;
    chk("sb_empty", W'(sb.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
